// File: rtl/eval_pkg.sv
// Shared definitions for the evaluation feeder: pipeline tag markers, the
// NaN response for an empty RUN, command codes, FSM state encoding and
// small word-building helpers.
package eval_pkg;

    // Markers sent alongside each streamed sample.
    localparam logic [31:0] TAG_FIRST  = 32'h3F80_0000;  // +1.0
    localparam logic [31:0] TAG_LAST   = 32'hBF80_0000;  // -1.0
    localparam logic [31:0] TAG_MID    = 32'h0000_0000;

    // Quiet NaN returned when RUN finds an empty buffer.
    localparam logic [31:0] RESULT_NAN = 32'h7FC0_0000;

    // Widest index the helpers accept (DEPTH tops out at 64).
    localparam int IDX_W = 7;

    // Command code carried in datab[1:0].
    typedef enum logic [1:0] {
        CMD_PUSH   = 2'd0,
        CMD_RUN    = 2'd1,
        CMD_CLEAR  = 2'd2,
        CMD_STATUS = 2'd3
    } cmd_e;

    // Feeder control states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    // Marker for sample idx of a cnt-long stream; LAST wins over FIRST so a
    // single-sample stream is tagged LAST.
    function automatic logic [31:0] sel_tag(input logic [IDX_W-1:0] idx,
                                            input logic [IDX_W-1:0] cnt);
        logic [31:0] tag;
        if (idx == (cnt - 7'd1)) begin
            tag = TAG_LAST;
        end else if (idx == 7'd0) begin
            tag = TAG_FIRST;
        end else begin
            tag = TAG_MID;
        end
        return tag;
    endfunction

    // STATUS response layout: {15 zero bits, overflow, 16-bit count}.
    function automatic logic [31:0] status_word(input logic        ovf,
                                                input logic [15:0] cnt);
        return {15'd0, ovf, cnt};
    endfunction

endpackage

// File: rtl/eval_feeder_if.sv
// Bundle of the processor command port and the downstream pipeline port of
// the evaluation feeder. The master side is the environment (processor plus
// evaluation pipeline); the slave side is the feeder itself.
interface eval_feeder_if;

    // Processor command side
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic        done;
    logic [31:0] result;

    // Downstream evaluation pipeline side
    logic [31:0] x_out;
    logic [31:0] tag_out;
    logic        out_valid;
    logic [31:0] pipe_result;

    modport master (
        output clk_en,
        output start,
        output dataa,
        output datab,
        output pipe_result,
        input  done,
        input  result,
        input  x_out,
        input  tag_out,
        input  out_valid
    );

    modport slave (
        input  clk_en,
        input  start,
        input  dataa,
        input  datab,
        input  pipe_result,
        output done,
        output result,
        output x_out,
        output tag_out,
        output out_valid
    );

endinterface

// File: rtl/eval_sample_buf.sv
// Sample store for the evaluation feeder: DEPTH x 32-bit register array with
// one write port and one combinational read port. Contents are deliberately
// not reset; the owner's sample count guards every read.
module eval_sample_buf #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem_r [DEPTH];

    // Store one sample per write strobe.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/eval_feeder.sv
// Evaluation feeder: buffers float samples pushed by a processor custom
// instruction, replays them on RUN to a fixed-latency evaluation pipeline
// with FIRST/LAST markers, waits out the pipeline latency and returns the
// pipeline's accumulated result. No floating-point arithmetic is done here.
// PIPE_LAT must be at least 1.
module eval_feeder
    import eval_pkg::*;
#(
    parameter int DEPTH    = 32,
    parameter int PIPE_LAT = 40
) (
    input  logic          clock,
    input  logic          reset,
    eval_feeder_if.slave  bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int LW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
    localparam logic [LW-1:0] LAT_LOAD   = LW'(PIPE_LAT - 1);

    // Control state and registered outputs
    state_e        state_r;
    logic [CW-1:0] count_r;     // samples held
    logic          ovf_r;       // a PUSH was dropped since the last CLEAR
    logic [CW-1:0] idx_r;       // next sample to stream; zero outside STREAM
    logic [LW-1:0] lat_r;       // remaining DRAIN cycles before capture
    logic          done_r;
    logic [31:0]   result_r;
    logic [31:0]   x_r;
    logic [31:0]   tag_r;
    logic          valid_r;

    // Decode and buffer-port signals
    cmd_e          cmd_s;
    logic          accept_s;
    logic          wr_en_s;
    logic [31:0]   rd_data_s;
    logic [31:0]   cur_tag_s;
    logic          datab_unused_s;

    assign cmd_s          = cmd_e'(bus.datab[1:0]);
    assign datab_unused_s = ^bus.datab[31:2];
    assign accept_s       = (state_r == ST_IDLE) && bus.start && bus.clk_en;
    assign cur_tag_s      = sel_tag(IDX_W'(idx_r), IDX_W'(count_r));

    assign bus.done      = done_r;
    assign bus.result    = result_r;
    assign bus.x_out     = x_r;
    assign bus.tag_out   = tag_r;
    assign bus.out_valid = valid_r;

    // Write into the buffer only for an accepted PUSH that still has room.
    always_comb begin
        wr_en_s = 1'b0;
        if (accept_s && (cmd_s == CMD_PUSH) && (count_r != COUNT_FULL)) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    eval_sample_buf #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .clock (clock),
        .we    (wr_en_s),
        .waddr (count_r[AW-1:0]),
        .wdata (bus.dataa),
        .raddr (idx_r[AW-1:0]),
        .rdata (rd_data_s)
    );

    // Command FSM with registered done/result and streaming outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            count_r  <= '0;
            ovf_r    <= 1'b0;
            idx_r    <= '0;
            lat_r    <= '0;
            done_r   <= 1'b0;
            result_r <= 32'd0;
            x_r      <= 32'd0;
            tag_r    <= 32'd0;
            valid_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    valid_r <= 1'b0;
                    x_r     <= 32'd0;
                    tag_r   <= 32'd0;
                    if (accept_s) begin
                        case (cmd_s)
                            CMD_PUSH: begin
                                if (count_r == COUNT_FULL) begin
                                    ovf_r    <= 1'b1;
                                    result_r <= 32'(count_r);
                                end else begin
                                    count_r  <= count_r + CW'(1);
                                    result_r <= 32'(count_r + CW'(1));
                                end
                                done_r  <= 1'b1;
                                state_r <= ST_RESP;
                            end
                            CMD_CLEAR: begin
                                count_r  <= '0;
                                ovf_r    <= 1'b0;
                                result_r <= 32'd0;
                                done_r   <= 1'b1;
                                state_r  <= ST_RESP;
                            end
                            CMD_STATUS: begin
                                result_r <= status_word(ovf_r, 16'(count_r));
                                done_r   <= 1'b1;
                                state_r  <= ST_RESP;
                            end
                            CMD_RUN: begin
                                if (count_r == '0) begin
                                    result_r <= RESULT_NAN;
                                    done_r   <= 1'b1;
                                    state_r  <= ST_RESP;
                                end else begin
                                    // idx_r is zero here, so sample 0 goes out
                                    // in the cycle right after acceptance.
                                    x_r     <= rd_data_s;
                                    tag_r   <= cur_tag_s;
                                    valid_r <= 1'b1;
                                    idx_r   <= idx_r + CW'(1);
                                    state_r <= ST_STREAM;
                                end
                            end
                            default: begin
                                state_r <= ST_IDLE;
                            end
                        endcase
                    end
                end

                ST_STREAM: begin
                    if (idx_r == count_r) begin
                        // Every sample is out; start the latency countdown.
                        valid_r <= 1'b0;
                        x_r     <= 32'd0;
                        tag_r   <= 32'd0;
                        idx_r   <= '0;
                        lat_r   <= LAT_LOAD;
                        state_r <= ST_DRAIN;
                    end else if (bus.clk_en) begin
                        x_r     <= rd_data_s;
                        tag_r   <= cur_tag_s;
                        valid_r <= 1'b1;
                        idx_r   <= idx_r + CW'(1);
                    end else begin
                        // Stall: hold position, present nothing.
                        valid_r <= 1'b0;
                        x_r     <= 32'd0;
                        tag_r   <= 32'd0;
                    end
                end

                ST_DRAIN: begin
                    // Counts every cycle; clk_en does not pause the pipeline wait.
                    if (lat_r == '0) begin
                        result_r <= bus.pipe_result;
                        done_r   <= 1'b1;
                        state_r  <= ST_RESP;
                    end else begin
                        lat_r <= lat_r - LW'(1);
                    end
                end

                ST_RESP: begin
                    state_r <= ST_IDLE;
                end

                default: begin
                    state_r <= ST_IDLE;
                    valid_r <= 1'b0;
                    x_r     <= 32'd0;
                    tag_r   <= 32'd0;
                    idx_r   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eval_feeder.sv
// Self-checking bench for eval_feeder. A behavioural model (sample array,
// count, overflow flag and closed-form cycle timing) predicts every response.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_eval_feeder;

    localparam int DEPTH    = 32;
    localparam int PIPE_LAT = 40;

    localparam logic [31:0] T_FIRST = 32'h3F80_0000;
    localparam logic [31:0] T_LAST  = 32'hBF80_0000;
    localparam logic [31:0] NAN_RES = 32'h7FC0_0000;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    eval_feeder_if bus_if ();

    eval_feeder #(
        .DEPTH    (DEPTH),
        .PIPE_LAT (PIPE_LAT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [31:0] model_buf [0:63];
    int          model_count = 0;
    bit          model_ovf   = 1'b0;

    function automatic logic [31:0] model_status();
        return {15'd0, model_ovf, 16'(model_count)};
    endfunction

    // Issue one command and wait (bounded) for done; lat = -1 on timeout.
    task automatic issue_cmd(input logic [1:0] code, input logic [31:0] data,
                             output logic [31:0] res, output int lat);
        logic [29:0] junk;
        junk = 30'($urandom());
        lat  = -1;
        res  = 32'd0;
        bus_if.start  = 1'b1;
        bus_if.clk_en = 1'b1;
        bus_if.dataa  = data;
        bus_if.datab  = {junk, code};
        @(negedge clock);
        bus_if.start = 1'b0;
        bus_if.dataa = $urandom();
        for (int k = 1; k <= 8; k++) begin
            if (bus_if.done === 1'b1) begin
                lat = k;
                res = bus_if.result;
                break;
            end
            @(negedge clock);
        end
        @(negedge clock);
    endtask

    // Push into the model and the DUT, returning the model's expected result.
    task automatic do_push(input logic [31:0] v, output logic [31:0] exp_res,
                           output logic [31:0] res, output int lat);
        if (model_count < DEPTH) begin
            model_buf[model_count] = v;
            model_count++;
        end else begin
            model_ovf = 1'b1;
        end
        exp_res = 32'(model_count);
        issue_cmd(2'd0, v, res, lat);
    endtask

    task automatic do_clear();
        logic [31:0] res;
        int          lat;
        model_count = 0;
        model_ovf   = 1'b0;
        issue_cmd(2'd2, $urandom(), res, lat);
        vectors++;
        if (lat !== 1 || res !== 32'd0) begin
            miscompares++;
            $display("FAIL clear: lat=%0d result=%h, want lat=1 result=00000000", lat, res);
        end
    endtask

    task automatic test_reset();
        logic [31:0] res;
        int          lat;
        reset = 1'b1;
        bus_if.clk_en      = 1'b0;
        bus_if.start       = 1'b0;
        bus_if.dataa       = 32'd0;
        bus_if.datab       = 32'd0;
        bus_if.pipe_result = 32'd0;
        repeat (3) @(negedge clock);
        vectors++;
        if (bus_if.done !== 1'b0 || bus_if.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctl: done=%b out_valid=%b, want 0 0", bus_if.done, bus_if.out_valid);
        end
        vectors++;
        if (bus_if.result !== 32'd0 || bus_if.x_out !== 32'd0 || bus_if.tag_out !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_data: result=%h x_out=%h tag_out=%h, want all 0",
                     bus_if.result, bus_if.x_out, bus_if.tag_out);
        end
        reset = 1'b0;
        @(negedge clock);
        issue_cmd(2'd3, 32'd0, res, lat);
        vectors++;
        if (lat !== 1 || res !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_status: lat=%0d result=%h, want lat=1 result=00000000", lat, res);
        end
    endtask

    task automatic test_push_status();
        logic [31:0] vals [3];
        logic [31:0] res, exp_res;
        int          lat;
        vals[0] = 32'h3F80_0000;
        vals[1] = 32'h4000_0000;
        vals[2] = 32'h4040_0000;
        for (int i = 0; i < 3; i++) begin
            do_push(vals[i], exp_res, res, lat);
            vectors++;
            if (lat !== 1 || res !== exp_res) begin
                miscompares++;
                $display("FAIL push_%0d: lat=%0d result=%h, want lat=1 result=%h", i, lat, res, exp_res);
            end
        end
        issue_cmd(2'd3, 32'd0, res, lat);
        vectors++;
        if (lat !== 1 || res !== 32'h0000_0003) begin
            miscompares++;
            $display("FAIL push_status: lat=%0d result=%h, want lat=1 result=00000003", lat, res);
        end
    endtask

    // RUN on the model's buffer, checking every cycle up to two past done.
    // pause_p > 0 drops clk_en in cycles pause_p and pause_p+1 (needs
    // pause_p <= count-1); poke raises a CLEAR strobe in cycle 2.
    task automatic test_run_stream(input string name, input int pause_p,
                                   input bit poke, input bit fixed_pipe);
        int          n, last_k, exp_done, exp_idx;
        logic [31:0] base, exp_res, exp_x, exp_tag;
        logic [29:0] junk;
        bit          exp_v;
        n        = model_count;
        base     = fixed_pipe ? 32'h4228_0000 : 32'($urandom());
        last_k   = (pause_p > 0) ? n + 2 : n;
        exp_done = (n == 0) ? 1 : last_k + PIPE_LAT + 1;
        exp_res  = (n == 0) ? NAN_RES : (fixed_pipe ? base : base + 32'(exp_done - 1));
        junk = 30'($urandom());
        bus_if.start       = 1'b1;
        bus_if.clk_en      = 1'b1;
        bus_if.datab       = {junk, 2'd1};
        bus_if.pipe_result = base;
        for (int k = 1; k <= exp_done + 2; k++) begin
            @(negedge clock);
            bus_if.start = 1'b0;
            exp_idx = -1;
            if (n > 0) begin
                if (pause_p == 0 || k <= pause_p) exp_idx = k - 1;
                else if (k >= pause_p + 3) exp_idx = k - 3;
                if (exp_idx >= n) exp_idx = -1;
            end
            exp_v   = (exp_idx >= 0);
            exp_x   = exp_v ? model_buf[exp_idx] : 32'd0;
            exp_tag = !exp_v ? 32'd0 : (exp_idx == n - 1) ? T_LAST :
                      (exp_idx == 0) ? T_FIRST : 32'd0;
            vectors++;
            if (bus_if.out_valid !== exp_v) begin
                miscompares++;
                $display("FAIL %s out_valid cyc %0d: got %b want %b", name, k, bus_if.out_valid, exp_v);
            end
            vectors++;
            if (bus_if.x_out !== exp_x) begin
                miscompares++;
                $display("FAIL %s x_out cyc %0d: got %h want %h", name, k, bus_if.x_out, exp_x);
            end
            vectors++;
            if (bus_if.tag_out !== exp_tag) begin
                miscompares++;
                $display("FAIL %s tag_out cyc %0d: got %h want %h", name, k, bus_if.tag_out, exp_tag);
            end
            vectors++;
            if (bus_if.done !== (k == exp_done)) begin
                miscompares++;
                $display("FAIL %s done cyc %0d: got %b want %b", name, k, bus_if.done, (k == exp_done));
            end
            if (k >= exp_done) begin
                vectors++;
                if (bus_if.result !== exp_res) begin
                    miscompares++;
                    $display("FAIL %s result cyc %0d: got %h want %h", name, k, bus_if.result, exp_res);
                end
            end
            bus_if.pipe_result = fixed_pipe ? base : base + 32'(k);
            if (pause_p > 0 && (k == pause_p || k == pause_p + 1)) bus_if.clk_en = 1'b0;
            else if (n > 0 && k > last_k && k < exp_done) bus_if.clk_en = 1'($urandom_range(0, 1));
            else bus_if.clk_en = 1'b1;
            if (poke && k == 2) begin
                bus_if.start = 1'b1;
                bus_if.datab = {junk, 2'd2};
            end
        end
        bus_if.start  = 1'b0;
        bus_if.clk_en = 1'b1;
    endtask

    task automatic test_overflow();
        logic [31:0] res, exp_res;
        int          lat;
        do_clear();
        for (int i = 0; i < DEPTH + 1; i++) begin
            do_push($urandom(), exp_res, res, lat);
            vectors++;
            if (lat !== 1 || res !== exp_res) begin
                miscompares++;
                $display("FAIL ovf_push_%0d: lat=%0d result=%h, want lat=1 result=%h", i, lat, res, exp_res);
            end
        end
        issue_cmd(2'd3, 32'd0, res, lat);
        vectors++;
        if (lat !== 1 || res !== 32'h0001_0020 || res !== model_status()) begin
            miscompares++;
            $display("FAIL ovf_status: lat=%0d result=%h, want lat=1 result=00010020", lat, res);
        end
    endtask

    task automatic test_clear_status();
        logic [31:0] res;
        int          lat;
        do_clear();
        issue_cmd(2'd3, 32'd0, res, lat);
        vectors++;
        if (lat !== 1 || res !== 32'd0) begin
            miscompares++;
            $display("FAIL clear_status: lat=%0d result=%h, want lat=1 result=00000000", lat, res);
        end
    endtask

    task automatic test_random_runs();
        logic [31:0] res, exp_res;
        int          lat, n;
        for (int it = 0; it < 3; it++) begin
            do_clear();
            n = (it == 0) ? 1 : $urandom_range(2, 8);
            for (int i = 0; i < n; i++) begin
                do_push($urandom(), exp_res, res, lat);
                vectors++;
                if (lat !== 1 || res !== exp_res) begin
                    miscompares++;
                    $display("FAIL rand_push_%0d_%0d: lat=%0d result=%h, want %h", it, i, lat, res, exp_res);
                end
            end
            test_run_stream("run_random", 0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_pause_start();
        logic [31:0] res, exp_res;
        int          lat;
        do_clear();
        for (int i = 0; i < 8; i++) begin
            do_push($urandom(), exp_res, res, lat);
        end
        test_run_stream("run_pause", $urandom_range(3, 7), 1'b1, 1'b0);
        issue_cmd(2'd3, 32'd0, res, lat);
        vectors++;
        if (lat !== 1 || res !== model_status()) begin
            miscompares++;
            $display("FAIL pause_status: lat=%0d result=%h, want lat=1 result=%h", lat, res, model_status());
        end
    endtask

    task automatic test_ignored_start();
        logic [31:0] res;
        int          pulses;
        int          lat;
        pulses = 0;
        bus_if.clk_en = 1'b0;
        bus_if.start  = 1'b1;
        bus_if.datab  = 32'd2;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (bus_if.done === 1'b1) pulses++;
        end
        bus_if.start  = 1'b0;
        bus_if.clk_en = 1'b1;
        @(negedge clock);
        if (bus_if.done === 1'b1) pulses++;
        vectors++;
        if (pulses !== 0) begin
            miscompares++;
            $display("FAIL gated_start_done: got %0d pulses want 0", pulses);
        end
        issue_cmd(2'd3, 32'd0, res, lat);
        vectors++;
        if (lat !== 1 || res !== model_status()) begin
            miscompares++;
            $display("FAIL gated_start_status: lat=%0d result=%h, want lat=1 result=%h", lat, res, model_status());
        end
    endtask

    task automatic test_reset_drain();
        logic [31:0] res, exp_res;
        int          lat, pulses, valids;
        do_clear();
        for (int i = 0; i < 4; i++) begin
            do_push($urandom(), exp_res, res, lat);
        end
        bus_if.start        = 1'b1;
        bus_if.datab        = 32'd1;
        bus_if.pipe_result  = 32'h1234_5678;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clock);
            bus_if.start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_count = 0;
        model_ovf   = 1'b0;
        vectors++;
        if (bus_if.out_valid !== 1'b0 || bus_if.done !== 1'b0 || bus_if.result !== 32'd0 ||
            bus_if.x_out !== 32'd0 || bus_if.tag_out !== 32'd0) begin
            miscompares++;
            $display("FAIL drain_reset: valid=%b done=%b result=%h x=%h tag=%h, want all 0",
                     bus_if.out_valid, bus_if.done, bus_if.result, bus_if.x_out, bus_if.tag_out);
        end
        pulses = 0;
        valids = 0;
        for (int k = 0; k < PIPE_LAT + 8; k++) begin
            @(negedge clock);
            if (bus_if.done === 1'b1) pulses++;
            if (bus_if.out_valid === 1'b1) valids++;
        end
        vectors++;
        if (pulses !== 0 || valids !== 0) begin
            miscompares++;
            $display("FAIL drain_reset_quiet: done pulses=%0d valids=%0d, want 0 0", pulses, valids);
        end
        issue_cmd(2'd3, 32'd0, res, lat);
        vectors++;
        if (lat !== 1 || res !== 32'd0) begin
            miscompares++;
            $display("FAIL drain_reset_status: lat=%0d result=%h, want lat=1 result=00000000", lat, res);
        end
    endtask

    initial begin
        test_reset();
        test_push_status();
        test_run_stream("run_basic", 0, 1'b0, 1'b1);
        test_run_stream("run_replay", 0, 1'b0, 1'b0);
        test_overflow();
        test_run_stream("run_full", 0, 1'b0, 1'b0);
        test_clear_status();
        test_run_stream("run_empty", 0, 1'b0, 1'b0);
        test_random_runs();
        test_pause_start();
        test_ignored_start();
        test_reset_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/eval_feeder.md
EVAL_FEEDER -- requirements
Module: eval_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 32, buffer capacity in 32-bit samples (2..64).
REQ-002 SHALL have parameter PIPE_LAT, default 40, fixed cycles from a sample on x_out to its value on pipe_result.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 clk_en  input  1  high = accept commands and advance streaming.
REQ-006 start  input  1  one-cycle command strobe from processor.
REQ-007 dataa  input  32  command operand (float sample for PUSH).
REQ-008 datab  input  32  command code in datab[1:0]: 0 PUSH, 1 RUN, 2 CLEAR, 3 STATUS; upper bits ignored.
REQ-009 done  output  1  one-cycle completion pulse per accepted command.
REQ-010 result  output  32  command result, stable while done high and held afterwards.
REQ-011 x_out  output  32  sample to downstream evaluation pipeline.
REQ-012 tag_out  output  32  marker to pipeline: 0x3F800000 first, 0xBF800000 last, 0x00000000 otherwise.
REQ-013 out_valid  output  1  x_out/tag_out carry a sample this cycle.
REQ-014 pipe_result  input  32  accumulated float result from downstream pipeline.

Function
REQ-015 FSM states IDLE, STREAM, DRAIN, RESP; commands accepted only in IDLE with start and clk_en high.
REQ-016 start outside IDLE or with clk_en low SHALL be ignored, with no done pulse.
REQ-017 PUSH: write dataa at index count, count+1; done and result = new count one cycle after start.
REQ-018 PUSH with count==DEPTH: sample dropped, overflow flag set, done still pulses, result = DEPTH.
REQ-019 CLEAR: count=0, overflow=0; done one cycle after start, result 0.
REQ-020 STATUS: done one cycle after start, result = {15'b0, overflow, 16-bit count}; no state change.
REQ-021 RUN with count==0: done one cycle after start, result 0x7FC00000 (NaN); no streaming.
REQ-022 RUN with count>0: start sampled at T0 enters STREAM; sample k (0-based) driven with out_valid at T0+1+k.
REQ-023 tag_out: k==count-1 LAST, else k==0 FIRST, else zero; count==1 yields LAST.
REQ-024 clk_en low in STREAM: out_valid 0, index frozen; resumes in order when clk_en returns.
REQ-025 After last sample, DRAIN counts PIPE_LAT cycles regardless of clk_en, then samples pipe_result into result.
REQ-026 done pulses the cycle after that capture: T0+count+PIPE_LAT+1 with clk_en held high; FSM then IDLE via RESP.
REQ-027 RUN SHALL NOT consume the buffer; repeated RUN replays identical samples.
REQ-028 out_valid 0 and x_out/tag_out 0 whenever not streaming a sample.

Reset
REQ-029 reset overrides all, including mid-STREAM/DRAIN: next cycle state IDLE, count 0, overflow 0, done 0, result 0, out_valid 0, x_out 0, tag_out 0.
REQ-030 Buffer contents need not be cleared by reset; unreadable since count is 0.

Structure
REQ-031 Shared package eval_pkg SHALL hold TAG_FIRST, TAG_LAST, TAG_MID, RESULT_NAN, command codes, FSM state encoding.
REQ-032 Buffer SHALL be one sub-module eval_sample_buf: DEPTH x 32 register array, one write port, one synchronous-free combinational read port.
REQ-033 Block SHALL contain no floating-point arithmetic.

Verification
REQ-034 PUSH 1.0, 2.0, 3.0 -> done each one cycle later, results 1, 2, 3; STATUS -> 0x00000003.
REQ-035 RUN on those 3 with pipe_result forced 0x42280000 -> x_out 1.0/2.0/3.0 at T0+1..3, tags FIRST/MID/LAST, done at T0+44, result 0x42280000.
REQ-036 33 PUSHes with DEPTH 32 -> 33rd result 32; STATUS 0x00010020; CLEAR -> STATUS 0x00000000.
REQ-037 RUN with count 0 -> done at T0+1, result 0x7FC00000, out_valid never high.
REQ-038 clk_en low two cycles mid-STREAM plus start during STREAM -> two-cycle gap, order intact, start ignored, done shifted by 2.
REQ-039 reset asserted during DRAIN -> next cycle IDLE, out_valid 0, STATUS 0, no done.
